// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier that uses the external combinational Shifter.
// It handles one multiplier bit per RUN cycle and returns a wrapped product plus a true-overflow flag.
module shift_add_multiplier #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] sh_value,
    output logic [7:0]       sh_amount,
    input  logic [WIDTH-1:0] sh_result,
    output logic [WIDTH-1:0] product,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic             ovf_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] product_q;
    logic             overflow_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] acc_d;
    logic             ovf_d;
    logic             carry_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] lost_mask_s;
    logic             lost_s;
    logic [WIDTH-1:0] above_mask_s;
    logic             last_s;

    // Accumulate step: the Shifter drops the top idx bits of A, so check A directly for lost bits
    always_comb begin
        {carry_s, sum_s} = {1'b0, acc_q} + {1'b0, sh_result};
        lost_mask_s      = ~({WIDTH{1'b1}} >> idx_q);
        lost_s           = |(a_q & lost_mask_s);
        above_mask_s     = ({WIDTH{1'b1}} << idx_q) << 1;
        last_s           = (idx_q == IDX_W'(WIDTH - 1)) || ((b_q & above_mask_s) == {WIDTH{1'b0}});
        if (b_q[idx_q]) begin
            acc_d = sum_s;
            ovf_d = ovf_q | carry_s | lost_s;
        end else begin
            acc_d = acc_q;
            ovf_d = ovf_q;
        end
    end

    // Control FSM with registered product, flags and handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            a_q        <= {WIDTH{1'b0}};
            b_q        <= {WIDTH{1'b0}};
            acc_q      <= {WIDTH{1'b0}};
            ovf_q      <= 1'b0;
            idx_q      <= {IDX_W{1'b0}};
            product_q  <= {WIDTH{1'b0}};
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q        <= multiplicand;
                        b_q        <= multiplier;
                        acc_q      <= {WIDTH{1'b0}};
                        ovf_q      <= 1'b0;
                        idx_q      <= {IDX_W{1'b0}};
                        product_q  <= {WIDTH{1'b0}};
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_d;
                    if (last_s) begin
                        product_q  <= acc_d;
                        overflow_q <= ovf_d;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sh_value  = a_q;
    assign sh_amount = (state_q == ST_RUN) ? {{(8 - IDX_W){1'b0}}, idx_q} : 8'd0;
    assign product   = product_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: a behavioural Shifter plus a cycle-level
// reference model built on plain A*B arithmetic and the run length derived from B.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic [15:0] sh_value;
    logic [7:0]  sh_amount;
    logic [15:0] sh_result;
    logic [15:0] product;
    logic        overflow;
    logic        busy;
    logic        done;

    int tests = 0;
    int failed = 0;

    shift_add_multiplier dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .sh_value     (sh_value),
        .sh_amount    (sh_amount),
        .sh_result    (sh_result),
        .product      (product),
        .overflow     (overflow),
        .busy         (busy),
        .done         (done)
    );

    assign sh_result = sh_value << sh_amount;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int run_len(input logic [15:0] b);
        for (int i = 15; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 1;
    endfunction

    // Reference model: 0 idle, 1 run, 2 done
    int          m_state = 0;
    int          m_step  = 0;
    int          m_len   = 0;
    logic [15:0] m_a     = 16'd0;
    logic [15:0] m_b     = 16'd0;
    logic [15:0] m_prod  = 16'd0;
    logic        m_ovf   = 1'b0;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b1;
            m_state <= 0;
            m_step  <= 0;
            m_a     <= 16'd0;
            m_b     <= 16'd0;
            m_prod  <= 16'd0;
            m_ovf   <= 1'b0;
        end else if (start && m_state != 1) begin
            m_a     <= multiplicand;
            m_b     <= multiplier;
            m_len   <= run_len(multiplier);
            m_step  <= 0;
            m_state <= 1;
            m_prod  <= 16'd0;
            m_ovf   <= 1'b0;
        end else if (m_state == 1) begin
            if (m_step + 1 == m_len) begin
                m_state <= 2;
                m_prod  <= 16'(32'(m_a) * 32'(m_b));
                m_ovf   <= (32'(m_a) * 32'(m_b)) >= 32'd65536;
            end else begin
                m_step <= m_step + 1;
            end
        end else begin
            m_state <= 0;
        end
    end

    // Compare every cycle once the model has seen reset
    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", 32'(busy), 32'(m_state == 1));
            check("done", 32'(done), 32'(m_state == 2));
            check("product", 32'(product), 32'(m_prod));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("sh_value", 32'(sh_value), 32'(m_a));
            check("sh_amount", 32'(sh_amount), (m_state == 1) ? 32'(m_step) : 32'd0);
        end
    end

    task automatic kick(input logic [15:0] a, input logic [15:0] b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input int gap, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_p, input logic exp_o, input int exp_lat);
        int lat;
        repeat (gap) @(negedge clk);
        kick(a, b);
        wait_done(0, lat);
        check("latency", 32'(lat), 32'(exp_lat));
        check("done_pulse", 32'(done), 32'd1);
        check("lit_product", 32'(product), 32'(exp_p));
        check("lit_overflow", 32'(overflow), 32'(exp_o));
        check("model_product", 32'(m_prod), 32'(exp_p));
        check("model_overflow", 32'(m_ovf), 32'(exp_o));
    endtask

    initial begin
        int lat;
        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = 16'd0;
        multiplier   = 16'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_product", 32'(product), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        run_op(1, 16'd3, 16'd5, 16'd15, 1'b0, 3);
        run_op(1, 16'd1234, 16'd0, 16'd0, 1'b0, 1);
        run_op(1, 16'hFFFF, 16'd2, 16'd65534, 1'b1, 2);
        run_op(1, 16'd256, 16'd256, 16'd0, 1'b1, 9);
        run_op(1, 16'd1, 16'h8000, 16'd32768, 1'b0, 16);
        run_op(1, 16'hFFFF, 16'hFFFF, 16'd1, 1'b1, 16);
        run_op(0, 16'd12, 16'd3, 16'd36, 1'b0, 2);

        // start pulsed mid-RUN must be ignored
        @(negedge clk);
        kick(16'd7, 16'd9);
        @(negedge clk);
        multiplicand = 16'd2;
        multiplier   = 16'd2;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2, lat);
        check("ignore_latency", 32'(lat), 32'd4);
        check("ignore_product", 32'(product), 32'd63);
        check("ignore_overflow", 32'(overflow), 32'd0);
        run_op(0, 16'd2, 16'd2, 16'd4, 1'b0, 2);

        // reset at idx=3 of a run discards it
        @(negedge clk);
        kick(16'd100, 16'h00FF);
        repeat (3) @(negedge clk);
        check("pre_rst_amount", 32'(sh_amount), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_product", 32'(product), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("midrst_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        run_op(0, 16'd100, 16'h00FF, 16'd25500, 1'b0, 8);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
